// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch unit and the control unit's decoder:
// instruction width, instruction field bit positions, the fetch FSM state
// type and a helper that slices the decoder-visible fields out of a word.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_W   = 32;

    // Field positions inside an ARM-style instruction word.
    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int OP_MSB    = 27;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 25;
    localparam int FUNCT_LSB = 20;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 12;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [COND_MSB-COND_LSB:0]   cond;
        logic [OP_MSB-OP_LSB:0]       op;
        logic [FUNCT_MSB-FUNCT_LSB:0] funct;
        logic [RD_MSB-RD_LSB:0]       rd;
    } instr_fields_t;

    function automatic instr_fields_t decode_fields(input logic [INSTR_W-1:0] word);
        instr_fields_t f;
        f.cond  = word[COND_MSB:COND_LSB];
        f.op    = word[OP_MSB:OP_LSB];
        f.funct = word[FUNCT_MSB:FUNCT_LSB];
        f.rd    = word[RD_MSB:RD_LSB];
        return f;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the fetch unit's instruction-memory bus and its decode-side
// handshake/field outputs.
//   master : the fetch unit (drives imem_req/imem_addr and the IR outputs)
//   slave  : the surrounding memory + control unit/datapath
// Signals:
//   imem_req, imem_addr          fetch request and address (= pc)
//   imem_rvalid, imem_rdata      read response, one cycle per request
//   instr_valid, dec_ready       IR valid/ready handshake toward decode
//   pc_src, branch_target        redirect, sampled only on accept
//   instr, cond, op, funct, rd   instruction register and its fields
//   pc, pc_plus8                 address of the IR instruction and pc+8
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    import cpu_pkg::*;

    logic                  imem_req;
    logic [ADDR_W-1:0]     imem_addr;
    logic                  imem_rvalid;
    logic [INSTR_W-1:0]    imem_rdata;

    logic                  instr_valid;
    logic                  dec_ready;
    logic                  pc_src;
    logic [ADDR_W-1:0]     branch_target;

    logic [INSTR_W-1:0]    instr;
    logic [3:0]            cond;
    logic [1:0]            op;
    logic [5:0]            funct;
    logic [3:0]            rd;
    logic [ADDR_W-1:0]     pc;
    logic [ADDR_W-1:0]     pc_plus8;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        output instr_valid,
        input  dec_ready, pc_src, branch_target,
        output instr, cond, op, funct, rd, pc, pc_plus8
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        input  instr_valid,
        output dec_ready, pc_src, branch_target,
        input  instr, cond, op, funct, rd, pc, pc_plus8
    );

endinterface

// File: rtl/pc_next_logic.sv
// ---------------------------------------------------------------------------
// pc_next_logic
// Combinational next-PC arithmetic for the fetch unit.
//   pc             in   current PC (word aligned)
//   pc_src         in   1 = take branch_target, 0 = sequential
//   branch_target  in   redirect address; bits [1:0] are forced to zero
//   pc_plus8       out  pc + 8 (ARM R15 read value), modulo 2^ADDR_W
//   pc_next        out  PC to load when the current instruction is accepted
// ---------------------------------------------------------------------------
module pc_next_logic #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc_plus8,
    output logic [ADDR_W-1:0] pc_next
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target_aligned;

    // Additions wrap naturally at ADDR_W bits.
    assign pc_plus4       = pc + ADDR_W'(4);
    assign pc_plus8       = pc + ADDR_W'(8);
    assign target_aligned = branch_target & ~ADDR_W'(3);
    assign pc_next        = pc_src ? target_aligned : pc_plus4;

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetches one 32-bit instruction at a time from instruction memory into the
// instruction register and holds it (valid/ready) until decode consumes it,
// then advances the PC sequentially or to the resolved branch target.
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   fetch    --   instr_fetch_unit_if.master (memory bus + decode side)
//   stall_cnt out [15:0] saturating stall-cycle counter, only when the
//                 IF_STALL_CNT_EN macro is defined
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_unit_if.master   fetch
`ifdef IF_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    fetch_state_t        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   pc_next;
    logic [ADDR_W-1:0]   pc_plus8;
    logic                accept;
    instr_fields_t       fields;

    pc_next_logic #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc            (pc_q),
        .pc_src        (fetch.pc_src),
        .branch_target (fetch.branch_target),
        .pc_plus8      (pc_plus8),
        .pc_next       (pc_next)
    );

    assign accept = valid_q & fetch.dec_ready;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        valid_d        = valid_q;
        fetch.imem_req = 1'b0;

        unique case (state_q)
            FETCH: begin
                // Request is suppressed while reset is held so it first
                // appears on the cycle after reset deasserts.
                fetch.imem_req = ~reset;
                if (fetch.imem_rvalid) begin
                    instr_d = fetch.imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    valid_d = 1'b0;
                    pc_d    = pc_next;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign fields            = decode_fields(instr_q);
    assign fetch.imem_addr   = pc_q;
    assign fetch.instr_valid = valid_q;
    assign fetch.instr       = instr_q;
    assign fetch.cond        = fields.cond;
    assign fetch.op          = fields.op;
    assign fetch.funct       = fields.funct;
    assign fetch.rd          = fields.rd;
    assign fetch.pc          = pc_q;
    assign fetch.pc_plus8    = pc_plus8;

`ifdef IF_STALL_CNT_EN
    // A stall is a cycle waiting on memory or waiting on decode.
    logic stall;
    assign stall = ((state_q == FETCH) && !fetch.imem_rvalid) ||
                   ((state_q == HOLD)  && !fetch.dec_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. A behavioural model tracks the
// fetch unit as "is an instruction held, which one, at which pc" and is
// advanced once per clock from the inputs the bench drives. Inputs change
// 1 time unit after the rising edge; outputs are compared 1 time unit after
// that (pre-edge combinational) or 1 unit after the next edge (registered).
// Define IF_STALL_CNT_EN to also check the stall counter.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef IF_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fetch (bus)
`ifdef IF_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic        m_has;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
`ifdef IF_STALL_CNT_EN
    logic [15:0] m_stall;
`endif

    task automatic set_inputs(input logic rv, input logic [31:0] rdw, input logic dr,
                              input logic ps, input logic [31:0] bt);
        bus.imem_rvalid   = rv;
        bus.imem_rdata    = rdw;
        bus.dec_ready     = dr;
        bus.pc_src        = ps;
        bus.branch_target = bt;
        #1;
    endtask

    // Advance the model by one clock using the currently driven inputs,
    // then let the DUT take the same edge.
    task automatic clock();
        if (reset) begin
            m_has   = 1'b0;
            m_pc    = RESET_PC;
            m_instr = 32'h0;
`ifdef IF_STALL_CNT_EN
            m_stall = 16'h0;
`endif
        end else if (!m_has) begin
            if (bus.imem_rvalid) begin
                m_instr = bus.imem_rdata;
                m_has   = 1'b1;
            end else begin
`ifdef IF_STALL_CNT_EN
                if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
            end
        end else begin
            if (bus.dec_ready) begin
                m_pc  = bus.pc_src ? {bus.branch_target[31:2], 2'b00} : m_pc + 32'd4;
                m_has = 1'b0;
            end else begin
`ifdef IF_STALL_CNT_EN
                if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        clock();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_inputs(1'b1, $urandom, 1'b1, 1'b1, $urandom);
        clock();
        clock();
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", bus.instr_valid);
        end
        checks++;
        if (bus.pc !== RESET_PC) begin
            failures++;
            $display("FAIL reset_pc got=%h exp=%h", bus.pc, RESET_PC);
        end
        checks++;
        if (bus.instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_instr got=%h exp=0", bus.instr);
        end
        reset = 1'b0;
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL reset_req got=%b/%h exp=1/%h", bus.imem_req, bus.imem_addr, RESET_PC);
        end
`ifdef IF_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_stall got=%0d exp=0", stall_cnt);
        end
`endif
    endtask

    task automatic test_first_fetch();
        do_reset();
        set_inputs(1'b1, 32'hE3A0_1005, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL first_req got=%b/%h exp=1/0", bus.imem_req, bus.imem_addr);
        end
        clock();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.cond !== 4'hE || bus.op !== 2'b00 ||
            bus.funct !== 6'b111010 || bus.rd !== 4'h1) begin
            failures++;
            $display("FAIL first_fields got=%b/%h/%b/%b/%h exp=1/e/00/111010/1",
                     bus.instr_valid, bus.cond, bus.op, bus.funct, bus.rd);
        end
        checks++;
        if (bus.pc !== 32'h0 || bus.pc_plus8 !== 32'h8) begin
            failures++;
            $display("FAIL first_pc got=%h/%h exp=0/8", bus.pc, bus.pc_plus8);
        end
        set_inputs(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL hold_req got=%b exp=0", bus.imem_req);
        end
        clock();
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h4) begin
            failures++;
            $display("FAIL first_accept got=%b/%h exp=0/4", bus.instr_valid, bus.imem_addr);
        end
    endtask

    task automatic test_delayed_rvalid();
        logic [31:0] data;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b0, $urandom, 1'b1, 1'($urandom), $urandom);
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
                failures++;
                $display("FAIL delay_req[%0d] got=%b/%h exp=1/0", i, bus.imem_req, bus.imem_addr);
            end
            clock();
            checks++;
            if (bus.instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL delay_valid[%0d] got=%b exp=0", i, bus.instr_valid);
            end
        end
        data = $urandom;
        set_inputs(1'b1, data, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL delay_req[3] got=%b/%h exp=1/0", bus.imem_req, bus.imem_addr);
        end
        clock();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== data) begin
            failures++;
            $display("FAIL delay_load got=%b/%h exp=1/%h", bus.instr_valid, bus.instr, data);
        end
`ifdef IF_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd3) begin
            failures++;
            $display("FAIL delay_stall got=%0d exp=3", stall_cnt);
        end
`endif
    endtask

    // Entered in HOLD at pc 0 from the previous task.
    task automatic test_hold();
        logic [31:0] saved_instr;
        logic [31:0] saved_pc;
        saved_instr = m_instr;
        saved_pc    = m_pc;
        for (int i = 0; i < 5; i++) begin
            set_inputs(1'($urandom), $urandom, 1'b0, 1'(i % 2), $urandom);
            clock();
            checks++;
            if (bus.instr !== saved_instr || bus.pc !== saved_pc || bus.instr_valid !== 1'b1 ||
                bus.imem_req !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d] got=%h/%h/%b/%b exp=%h/%h/1/0", i, bus.instr, bus.pc,
                         bus.instr_valid, bus.imem_req, saved_instr, saved_pc);
            end
        end
`ifdef IF_STALL_CNT_EN
        checks++;
        if (stall_cnt !== m_stall) begin
            failures++;
            $display("FAIL hold_stall got=%0d exp=%0d", stall_cnt, m_stall);
        end
`endif
        set_inputs(1'b0, 32'h0, 1'b1, 1'b0, $urandom);
        clock();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== saved_pc + 32'd4) begin
            failures++;
            $display("FAIL hold_release got=%b/%h exp=1/%h", bus.imem_req, bus.imem_addr,
                     saved_pc + 32'd4);
        end
    endtask

    task automatic test_branch();
        set_inputs(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        clock();
        set_inputs(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0103);
        clock();
        checks++;
        if (bus.imem_addr !== 32'h0000_0100 || bus.pc !== 32'h0000_0100) begin
            failures++;
            $display("FAIL branch_align got=%h/%h exp=00000100", bus.imem_addr, bus.pc);
        end
    endtask

    task automatic test_wrap();
        set_inputs(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        clock();
        set_inputs(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        clock();
        set_inputs(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        clock();
        checks++;
        if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus8 !== 32'h0000_0004) begin
            failures++;
            $display("FAIL wrap_plus8 got=%h/%h exp=fffffffc/00000004", bus.pc, bus.pc_plus8);
        end
        set_inputs(1'b0, 32'h0, 1'b1, 1'b0, $urandom);
        clock();
        checks++;
        if (bus.imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_plus4 got=%h exp=0", bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        // Reset while FETCH is waiting, with a response arriving on that edge.
        do_reset();
        set_inputs(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        clock();
        set_inputs(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        clock();
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        clock();
        reset = 1'b1;
        set_inputs(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0200);
        clock();
        reset = 1'b0;
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.pc !== RESET_PC || bus.instr !== 32'h0) begin
            failures++;
            $display("FAIL rst_fetch got=%b/%h/%h exp=0/%h/0", bus.instr_valid, bus.pc,
                     bus.instr, RESET_PC);
        end
        // Reset while HOLD is being accepted with a redirect.
        set_inputs(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        clock();
        set_inputs(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        clock();
        set_inputs(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        clock();
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        clock();
        reset = 1'b1;
        set_inputs(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200);
        clock();
        reset = 1'b0;
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_addr !== RESET_PC || bus.imem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_hold got=%b/%h/%b exp=0/%h/1", bus.instr_valid, bus.imem_addr,
                     bus.imem_req, RESET_PC);
        end
`ifdef IF_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'h0) begin
            failures++;
            $display("FAIL rst_stall got=%0d exp=0", stall_cnt);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_inputs($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                       1'($urandom), $urandom);
            checks++;
            if (bus.imem_req !== !m_has || (!m_has && bus.imem_addr !== m_pc)) begin
                failures++;
                $display("FAIL rand_req[%0d] got=%b/%h exp=%b/%h", i, bus.imem_req,
                         bus.imem_addr, !m_has, m_pc);
            end
            clock();
            checks++;
            if (bus.instr_valid !== m_has || bus.pc !== m_pc || bus.instr !== m_instr ||
                bus.pc_plus8 !== m_pc + 32'd8 || bus.rd !== m_instr[15:12] ||
                bus.funct !== m_instr[25:20]) begin
                failures++;
                $display("FAIL rand_state[%0d] got=%b/%h/%h/%h exp=%b/%h/%h/%h", i,
                         bus.instr_valid, bus.pc, bus.instr, bus.pc_plus8,
                         m_has, m_pc, m_instr, m_pc + 32'd8);
            end
`ifdef IF_STALL_CNT_EN
            checks++;
            if (stall_cnt !== m_stall) begin
                failures++;
                $display("FAIL rand_stall[%0d] got=%0d exp=%0d", i, stall_cnt, m_stall);
            end
`endif
        end
    endtask

`ifdef IF_STALL_CNT_EN
    task automatic test_stall_saturate();
        do_reset();
        set_inputs(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (65540) clock();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL stall_sat got=%h exp=ffff", stall_cnt);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset = 1'b1;
        m_has   = 1'b0;
        m_pc    = RESET_PC;
        m_instr = 32'h0;
`ifdef IF_STALL_CNT_EN
        m_stall = 16'h0;
`endif
        test_reset();
        test_first_fetch();
        test_delayed_rvalid();
        test_hold();
        test_branch();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef IF_STALL_CNT_EN
        test_stall_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
